// File: rtl/div_seq.sv
// div_seq: sequencer and datapath for the iterative radix-2 MIPS DIV/DIVU divider
// Ports: clk/rst; startE, signedE, srcaE, srcbE, advE, annulE from the execute stage;
//        stall_div, busy, ready, hi (remainder) and lo (quotient) back to the pipeline.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             advE,
  input  logic             annulE,
  output logic             stall_div,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, rem_nx;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d, quo_nx;
  logic qsign_q, qsign_d, rsign_q, rsign_d;
  logic [WIDTH+1:0] rem_sh, diff;
  logic sa, sb, go, last;
  assign sa = signedE & srcaE[WIDTH-1];
  assign sb = signedE & srcbE[WIDTH-1];
  assign go = startE & ~annulE;
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  // quo_q starts as the dividend magnitude; its MSB shifts into the remainder
  // while quotient bits fill in from the bottom. diff's top bit is the borrow.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff = rem_sh - {2'b0, dvs_q};
  assign rem_nx = diff[WIDTH+1] ? rem_sh[WIDTH:0] : diff[WIDTH:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
  assign stall_div = ((state_q == IDLE && startE) || state_q == BUSY) && !annulE;
  assign busy = state_q == BUSY;
  assign ready = state_q == DONE;
  assign hi = hi_q;
  assign lo = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE && go && srcbE != '0) begin
      state_d = BUSY;
      quo_d = sa ? -srcaE : srcaE;
      dvs_d = sb ? -srcbE : srcbE;
      qsign_d = sa ^ sb;
      rsign_d = sa;
      cnt_d = '0;
      rem_d = '0;
    end else if (state_q == IDLE && go) begin
      state_d = DONE;
      lo_d = '1;
      hi_d = srcaE;
    end else if (state_q == BUSY && annulE) begin
      state_d = IDLE;
    end else if (state_q == BUSY) begin
      quo_d = quo_nx;
      rem_d = rem_nx;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        state_d = DONE;
        lo_d = qsign_q ? -quo_nx : quo_nx;
        hi_d = rsign_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
      end
    end else if (state_q == DONE && (annulE || advE)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq with a hi/lo scoreboard
module tb_div_seq;
  logic clk = 1'b0, rst = 1'b1, startE = 1'b0, signedE = 1'b0, advE = 1'b0, annulE = 1'b0;
  logic [31:0] srcaE = '0, srcbE = '0;
  logic stall_div, busy, ready;
  logic [31:0] hi, lo;
  int compared = 0, mismatched = 0;
  logic [63:0] sb_q[$];
  always #5 clk = ~clk;
  div_seq dut (
    .clk(clk), .rst(rst), .startE(startE), .signedE(signedE), .srcaE(srcaE), .srcbE(srcbE),
    .advE(advE), .annulE(annulE), .stall_div(stall_div), .busy(busy), .ready(ready),
    .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    chk({tag, "_stall"}, 32'(stall_div), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask
  // Called just after a rising edge with the FSM in IDLE; returns at the
  // falling edge of the first DONE cycle.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    logic got;
    logic [63:0] e;
    startE = 1'b1;
    signedE = sg;
    srcaE = a;
    srcbE = b;
    advE = 1'b0;
    sb_q.push_back({ehi, elo});
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
      else if (stall_div) n++;
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    chk("ready_seen", 32'(got), 32'd1);
    chk("stall_in_done", 32'(stall_div), 32'd0);
    if (got && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("hi", hi, e[63:32]);
      chk("lo", lo, e[31:0]);
    end
  endtask
  task automatic retire();
    @(posedge clk); #1;
    advE = 1'b1;
    startE = 1'b0;
    @(posedge clk); #1;
    advE = 1'b0;
    @(negedge clk);
    chk("retire_ready", 32'(ready), 32'd0);
    chk("retire_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset", 32'd0, 32'd0);
    @(posedge clk); #1;
    run_div(1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    retire();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    retire();
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    retire();
    run_div(1'b0, 32'h1234, 32'd0, 1, 32'h1234, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_stall", 32'(stall_div), 32'd0);
      chk("hold_ready", 32'(ready), 32'd1);
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_hi", hi, 32'h1234);
      chk("hold_lo", lo, 32'hFFFF_FFFF);
    end
    @(posedge clk); #1;
    advE = 1'b1;
    @(posedge clk); #1;
    run_div(1'b0, 32'd9, 32'd3, 33, 32'd0, 32'd3);
    retire();
    startE = 1'b1;
    annulE = 1'b1;
    srcaE = 32'd50;
    srcbE = 32'd5;
    @(negedge clk);
    chk("idle_annul_stall", 32'(stall_div), 32'd0);
    @(posedge clk); #1;
    startE = 1'b0;
    annulE = 1'b0;
    @(negedge clk);
    chk("idle_annul_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    startE = 1'b1;
    signedE = 1'b0;
    srcaE = 32'd1000;
    srcbE = 32'd10;
    repeat (10) @(posedge clk);
    #1 annulE = 1'b1;
    @(negedge clk);
    chk("annul_busy", 32'(busy), 32'd1);
    chk("annul_stall", 32'(stall_div), 32'd0);
    @(posedge clk); #1;
    annulE = 1'b0;
    startE = 1'b0;
    @(negedge clk);
    chk_idle("after_annul", 32'd0, 32'd3);
    @(posedge clk); #1;
    startE = 1'b1;
    srcaE = 32'd100;
    srcbE = 32'd7;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    startE = 1'b0;
    @(negedge clk);
    chk_idle("mid_reset", 32'd0, 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequencer for the iterative radix-2 divider used by MIPS DIV/DIVU in the 5-stage pipeline.
- Accepts a divide request from the execute stage and runs the divider for WIDTH iterations.
- Drives a stall request that the pipeline ORs into stallF/stallD/stallE.
- Holds the HI/LO result until the execute stage advances, and can be cancelled by an exception flush.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk      input   1      clock; all state updates on rising edge.
- rst      input   1      synchronous active-high reset.
- startE   input   1      divide instruction present in execute stage; level, held while the instruction sits in E.
- signedE  input   1      1 = DIV (signed), 0 = DIVU; sampled with the operands.
- srcaE    input   WIDTH  dividend (rs value after forwarding).
- srcbE    input   WIDTH  divisor (rt value after forwarding).
- advE     input   1      execute stage advances this cycle (E-register enable, i.e. not stalled).
- annulE   input   1      flush of the instruction in E (exception/branch flush).
- stall_div output 1      pipeline stall request.
- busy     output  1      iteration in progress.
- ready    output  1      result valid in hi/lo.
- hi       output  WIDTH  remainder.
- lo       output  WIDTH  quotient.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state IDLE, counter 0, hi=0, lo=0, stall_div=0, busy=0, ready=0.
- States: IDLE, BUSY, DONE.
- Combinational outputs:
  - stall_div = (IDLE & startE & ~annulE) | (BUSY & ~annulE).
  - busy = BUSY.
  - ready = DONE.
- IDLE transitions:
  - startE & ~annulE & srcbE != 0: latch |dividend|, |divisor|, quotient sign (sa^sb, signed only), remainder sign (sa, signed only); clear counter and partial remainder; go to BUSY.
  - startE & ~annulE & srcbE == 0: go to DONE with lo = all ones and hi = srcaE. Stall is asserted for exactly 1 cycle.
  - Otherwise stay in IDLE.
- BUSY:
  - One restoring shift-subtract step per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits so the subtract never overflows.
  - After WIDTH steps (counter == WIDTH-1 on the last step), go to DONE. Sign correction is applied in that same transition: two's-complement negate the quotient if qsign, and the remainder if rsign.
  - hi/lo are registered on entry to DONE.
- Latency:
  - Request first seen in IDLE at cycle T.
  - BUSY occupies cycles T+1 .. T+WIDTH.
  - DONE at T+WIDTH+1, with stall_div=0 in that cycle.
  - stall_div is high for WIDTH+1 cycles total.
- DONE:
  - hi/lo are held stable.
  - advE=1: go to IDLE next cycle. hi/lo keep their value until the next DONE entry.
  - advE=0 (stalled by another hazard): stay in DONE. startE remaining high must not restart the divider.
- Back-to-back divides: if DONE & advE and a new divide enters E the next cycle, it is seen in IDLE that cycle and the sequence restarts; no dead cycle beyond the IDLE evaluation.
- Annul:
  - annulE in BUSY or DONE: go to IDLE next cycle; stall_div drops in the same cycle.
  - hi/lo are not updated by an annulled operation; they keep the last committed result.
  - annulE in IDLE blocks a start.
- Overflow case (signed): -2^(WIDTH-1) / -1 yields lo = 0x80000000 and hi = 0. This falls out of the magnitude algorithm; no special case is needed.
- Reset asserted mid-BUSY or in DONE: IDLE next edge; all outputs return to reset values.
- rst has priority over annulE; annulE has priority over startE and advE.
- No X-propagation: operand registers are reset to 0.

Test Plan:
- DIVU 100/7: startE=1, signedE=0, held until ready -> stall_div high 33 cycles, then ready=1, lo=14, hi=2; advE=1 returns to IDLE.
- DIV -7/2: -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV 0x80000000/0xFFFFFFFF: -> lo=0x80000000, hi=0.
- Divide by zero (srca=0x1234, srcb=0): -> stall 1 cycle, ready next cycle, lo=0xFFFFFFFF, hi=0x1234.
- DONE held with advE=0 for 5 cycles while startE stays 1: -> no restart, stall_div=0, hi/lo stable. Then advE=1 followed immediately by a new DIVU 9/3: -> lo=3, hi=0 after 33 stall cycles.
- annulE asserted at BUSY cycle 10: -> stall_div drops that cycle, IDLE next, hi/lo keep the prior result. A separate run asserts rst at BUSY cycle 20: -> all outputs 0 next edge.
